// File: rtl/dla_sched_pkg.sv
// dla_sched_pkg: shared states, mode codes and widths for the PE row scheduler
package dla_sched_pkg;
  localparam int PSUM_W = 20;
  localparam int PIPE_LAT = 3;
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, STREAM, DRAIN, FIN} sched_state_e;
  typedef logic signed [PSUM_W-1:0] psum_t;
endpackage

// File: rtl/sched_out_fifo.sv
// sched_out_fifo: show-ahead FIFO that bypasses the write data straight to the head when empty
module sched_out_fifo #(
  parameter int W = 21,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic empty, store, deq;
  // an entry written while the FIFO is empty and popped in the same cycle never lands in storage
  assign empty = cnt_q == '0;
  assign store = wr_en_i && !(empty && rd_en_i);
  assign deq = rd_en_i && !empty;
  assign valid_o = !empty || wr_en_i;
  assign data_o = empty ? wr_data_i : mem_q[rd_q];
  assign count_o = cnt_q;
  // pointers and occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (deq) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(store) - CW'(deq);
    end
  // storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk)
    if (store) mem_q[wr_q] <= wr_data_i;
endmodule

// File: rtl/pe_row_sched.sv
// pe_row_sched: job sequencer for one PE row -- weight load, credited pixel stream, masked reduction, psum FIFO
module pe_row_sched #(
  parameter int NUM_PE = 16,
  parameter int PROD_W = 16,
  parameter int ACC_W = 20,
  parameter int ADDR_W = 10,
  parameter int OUT_DEPTH = 4
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [1:0]                     cfg_mode,
  input  logic [NUM_PE-1:0]              cfg_mask,
  input  logic [ADDR_W-1:0]              cfg_len,
  input  logic [ADDR_W-1:0]              cfg_wbase,
  input  logic [ADDR_W-1:0]              cfg_pbase,
  output logic                           w_rd_en,
  output logic [ADDR_W-1:0]              w_rd_addr,
  output logic                           w_load,
  output logic                           p_rd_en,
  output logic [ADDR_W-1:0]              p_rd_addr,
  output logic [1:0]                     row_mode,
  input  logic [NUM_PE-1:0][PROD_W-1:0]  product,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_psum,
  output logic                           out_last,
  output logic                           done,
  output logic                           err
);
  import dla_sched_pkg::*;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int UW = CW + 1;
  sched_state_e state_q, state_d;
  logic [1:0] mode_q;
  logic [NUM_PE-1:0] mask_q;
  logic [ADDR_W-1:0] len_q, wbase_q, pbase_q, k_q;
  logic [PIPE_LAT-1:0] vld_q, last_q;
  logic signed [ACC_W-1:0] psum_q, sum_d;
  logic err_q, accept, issue, last_rd, pop;
  logic [CW-1:0] fifo_cnt;
  logic [UW-1:0] used;
  assign accept = cfg_ready && cfg_valid;
  assign last_rd = k_q == len_q - ADDR_W'(1);
  assign pop = out_valid && out_ready;
  assign row_mode = mode_q;
  assign err = err_q;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: illegal modes stay in IDLE, empty jobs finish at once, DRAIN ends when the last psum leaves
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid && cfg_mode != MODE_ILLEGAL) state_d = (cfg_len == '0) ? FIN : LOAD_W;
      LOAD_W:  state_d = WAIT_W;
      WAIT_W:  state_d = STREAM;
      STREAM:  if (issue && last_rd) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs: a pixel read is issued only while in-flight tags plus queued psums leave a free FIFO slot
  always_comb begin
    used = UW'(fifo_cnt);
    for (int i = 0; i < PIPE_LAT; i++) used = used + UW'(vld_q[i]);
    issue = state_q == STREAM && used < UW'(OUT_DEPTH);
    cfg_ready = state_q == IDLE;
    w_rd_en = state_q == LOAD_W;
    w_rd_addr = w_rd_en ? wbase_q : '0;
    w_load = state_q == WAIT_W;
    p_rd_en = issue;
    p_rd_addr = issue ? pbase_q + k_q : '0;
    done = state_q == FIN;
  end
  // masked sum of sign-extended lane products; the width covers all lanes at the most negative product
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_PE; i++)
      if (mask_q[i]) sum_d = sum_d + ACC_W'($signed(product[i]));
  end
  // job registers, read counter, pipeline tags and the registered reduction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mode_q <= '0;
      mask_q <= '0;
      len_q <= '0;
      wbase_q <= '0;
      pbase_q <= '0;
      k_q <= '0;
      vld_q <= '0;
      last_q <= '0;
      psum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= cfg_mode;
        mask_q <= cfg_mask;
        len_q <= cfg_len;
        wbase_q <= cfg_wbase;
        pbase_q <= cfg_pbase;
      end
      k_q <= accept ? '0 : k_q + ADDR_W'(issue);
      vld_q <= {vld_q[PIPE_LAT-2:0], issue};
      last_q <= {last_q[PIPE_LAT-2:0], issue && last_rd};
      if (vld_q[PIPE_LAT-2]) psum_q <= sum_d;
      err_q <= accept && cfg_mode == MODE_ILLEGAL;
    end
  sched_out_fifo #(.W(ACC_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vld_q[PIPE_LAT-1]),
    .wr_data_i ({last_q[PIPE_LAT-1], psum_q}),
    .rd_en_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    ({out_last, out_psum}),
    .count_o   (fifo_cnt)
  );
endmodule

// File: tb/tb_pe_row_sched.sv
// tb_pe_row_sched: directed jobs with a behavioural PE row and a psum scoreboard
module tb_pe_row_sched;
  logic clk = 0, rst = 1;
  logic cfg_valid, cfg_ready, w_rd_en, w_load, p_rd_en, out_valid, out_ready, out_last, done, err;
  logic [1:0] cfg_mode, row_mode;
  logic [15:0] cfg_mask;
  logic [9:0] cfg_len, cfg_wbase, cfg_pbase, w_rd_addr, p_rd_addr;
  logic [15:0][15:0] product;
  logic signed [19:0] out_psum;
  int total = 0, bad = 0, cyc = 0;
  int wt[16], wl[16], pix_fix;
  logic [9:0] pa_q;
  int exp_psum[$];
  bit exp_last[$];
  int j_mode, j_len, j_wb, j_pb, rd_k;
  int n_rd, n_wr, n_wl, n_ov, n_err, n_pop, n_done, first_rd, first_ov, last_rd, last_pop;

  pe_row_sched dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_mask(cfg_mask), .cfg_len(cfg_len), .cfg_wbase(cfg_wbase), .cfg_pbase(cfg_pbase),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_load(w_load), .p_rd_en(p_rd_en),
    .p_rd_addr(p_rd_addr), .row_mode(row_mode), .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .out_psum(out_psum), .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pix(input logic [9:0] a);
    return pix_fix >= 0 ? pix_fix : int'(a[3:0]) + 1;
  endfunction

  // PE row: weights latched on w_load, pixel arrives one cycle after the read, product registered one more
  always @(posedge clk or negedge rst)
    if (!rst) begin
      pa_q <= '0;
      product <= '0;
      for (int i = 0; i < 16; i++) wl[i] <= 0;
    end else begin
      pa_q <= p_rd_addr;
      for (int i = 0; i < 16; i++) begin
        if (w_load) wl[i] <= wt[i];
        product[i] <= 16'(wl[i] * pix(pa_q));
      end
    end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {cfg_ready, w_rd_en, w_load, p_rd_en, out_valid, out_last, done, err, row_mode, out_psum, w_rd_addr, p_rd_addr},
        longint'(1) << 49);
  endtask

  task automatic push(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      exp_psum.push_back(p);
      exp_last.push_back(i == n - 1);
    end
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < 16; i++) wt[i] = v;
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] mk, input int len, input int wb, input int pb);
    j_mode = m; j_len = len; j_wb = wb; j_pb = pb; rd_k = 0;
    n_rd = 0; n_wr = 0; n_wl = 0; n_ov = 0; n_err = 0; n_pop = 0; n_done = 0;
    first_rd = -1; first_ov = -1; last_rd = -1; last_pop = -1;
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1; cfg_mode = m; cfg_mask = mk;
    cfg_len = 10'(len); cfg_wbase = 10'(wb); cfg_pbase = 10'(pb);
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic wait_done(input string nm, input int n);
    for (int i = 0; i < n && n_done == 0; i++) begin
      @(posedge clk); #1;
    end
    chk(nm, n_done, 1);
  endtask

  // monitor: read addresses, credit limit, scoreboard pops and done timing
  always @(negedge clk)
    if (rst) begin
      if (w_rd_en) begin n_wr++; chk("w_addr", w_rd_addr, j_wb); end
      if (w_load) n_wl++;
      if (err) n_err++;
      if (out_valid) begin n_ov++; if (first_ov < 0) first_ov = cyc; end
      if (p_rd_en) begin
        chk("p_addr", p_rd_addr, (j_pb + rd_k) % 1024);
        chk("row_mode", row_mode, j_mode);
        chk("credit", (n_rd - n_pop) < 4, 1);
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc; rd_k++; n_rd++;
      end
      if (out_valid && out_ready) begin
        if (exp_psum.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got psum %0d with nothing expected (cycle %0d)", out_psum, cyc);
        end else begin
          chk("psum", $signed(out_psum), exp_psum.pop_front());
          chk("last", out_last, exp_last.pop_front());
        end
        n_pop++; last_pop = cyc;
      end
      if (done) begin
        n_done++;
        if (j_len > 0) chk("done_timing", cyc, last_pop + 1);
      end
    end

  int bp[10] = '{208, 224, 240, 256, 16, 32, 48, 64, 80, 96};

  initial begin
    cfg_valid = 0; cfg_mode = 0; cfg_mask = 0; cfg_len = 0; cfg_wbase = 0; cfg_pbase = 0;
    out_ready = 1; pix_fix = 1; set_w(1); j_len = 0;
    #2 rst = 0;
    @(negedge clk); chk_reset("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    // basic: 16 lanes of 1*1
    push(16, 4);
    start(2'd0, 16'hFFFF, 4, 10'h040, 10'h100);
    wait_done("basic_done", 40);
    chk("basic_wload", n_wl, 1);
    chk("basic_reads", n_rd, 4);
    chk("basic_latency", first_ov - first_rd, 3);
    chk("basic_consec", last_rd - first_rd, 3);
    chk("basic_sb_empty", exp_psum.size(), 0);
    chk("basic_ready_back", cfg_ready, 1);
    // signed extreme: -128 * 255 on all lanes
    set_w(-128); pix_fix = 255;
    push(-522240, 1);
    start(2'd0, 16'hFFFF, 1, 10'h3FF, 10'h200);
    wait_done("extreme_done", 30);
    chk("extreme_sb_empty", exp_psum.size(), 0);
    // mask 7000, mode 1: lanes 12..14 with weights 13,14,15 and pixel 2
    for (int i = 0; i < 16; i++) wt[i] = i + 1;
    pix_fix = 2;
    push(84, 3);
    start(2'd1, 16'h7000, 3, 10'h010, 10'h050);
    wait_done("mask_done", 40);
    chk("mask_mode_held", row_mode, 1);
    chk("mask_sb_empty", exp_psum.size(), 0);
    // backpressure with address wrap
    set_w(1); pix_fix = -1; out_ready = 0;
    foreach (bp[i]) begin
      exp_psum.push_back(bp[i]);
      exp_last.push_back(i == 9);
    end
    start(2'd2, 16'hFFFF, 10, 10'h001, 10'h3FC);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_reads_stalled", n_rd, 4);
    chk("bp_no_pops", n_pop, 0);
    for (int i = 0; i < 200 && n_done == 0; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    chk("bp_done", n_done, 1);
    out_ready = 1;
    chk("bp_pops", n_pop, 10);
    chk("bp_sb_empty", exp_psum.size(), 0);
    // illegal mode
    start(2'b11, 16'hFFFF, 4, 10'h000, 10'h000);
    chk("err_pulse", err, 1);
    chk("err_ready", cfg_ready, 1);
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_no_reads", n_rd + n_wr + n_wl, 0);
    chk("err_count", n_err, 1);
    // empty job
    start(2'd0, 16'hFFFF, 0, 10'h000, 10'h000);
    wait_done("len0_done", 5);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_no_reads", n_rd + n_wr + n_wl, 0);
    chk("len0_no_valid", n_ov, 0);
    // reset after 3 of 8 reads
    pix_fix = 1;
    push(16, 8);
    start(2'd1, 16'hFFFF, 8, 10'h000, 10'h010);
    for (int i = 0; i < 30 && n_rd < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_at_three", n_rd, 3);
    rst = 0;
    exp_psum.delete();
    exp_last.delete();
    @(negedge clk); chk_reset("rst_mid_outputs");
    @(posedge clk); #1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", n_done, 0);
    set_w(2); pix_fix = 3;
    push(96, 2);
    start(2'd0, 16'hFFFF, 2, 10'h005, 10'h020);
    wait_done("post_rst_done", 40);
    chk("post_rst_reads", n_rd, 2);
    chk("post_rst_sb_empty", exp_psum.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_row_sched.md
Name: pe_row_sched

Overview:
- Sequencer for one 16-lane PE row, for example the mode-12 row whose lanes 12-14 accept broadcast pixel_cast.
- Accepts a job descriptor, then loads the row's weights once from the weight buffer.
- Streams cfg_len pixel vectors from the pixel buffer, tags in-flight data, and reduces the 16 lane products to one masked psum per step.
- Psums leave through a small credit-guarded output FIFO; sits between the DLA top controller and PE_row_mode12.

Parameters:
- NUM_PE, 16, lanes in the row.
- PROD_W, 16, signed product width per lane.
- ACC_W, 20, signed psum width (holds 16 x -32640).
- ADDR_W, 10, buffer address width.
- OUT_DEPTH, 4, output FIFO entries; must be >= 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- cfg_valid  in  1  job request
- cfg_ready  out  1  high only in IDLE
- cfg_mode  in  2  row mode; 2'b11 illegal
- cfg_mask  in  16  lane-include mask for the reduction
- cfg_len  in  ADDR_W  number of pixel steps
- cfg_wbase  in  ADDR_W  weight buffer address
- cfg_pbase  in  ADDR_W  first pixel buffer address
- w_rd_en  out  1  weight buffer read
- w_rd_addr  out  ADDR_W  weight address
- w_load  out  1  row latches weight bus this cycle
- p_rd_en  out  1  pixel/cast buffer read
- p_rd_addr  out  ADDR_W  pixel address (cast buffer shares it)
- row_mode  out  2  mode to the row, held for the whole job
- product  in  NUM_PE x PROD_W  signed lane products from the row
- out_valid  out  1  psum available
- out_ready  in  1  consumer accepts
- out_psum  out  ACC_W  signed psum
- out_last  out  1  marks the final psum of the job
- done  out  1  one-cycle pulse, job complete
- err  out  1  one-cycle pulse, illegal mode

Behaviour:
- Reset values: all outputs 0 except cfg_ready = 1; FIFO and in-flight tags cleared; FSM in IDLE.
- Handshakes are valid/ready; a transfer occurs when both are high at the clock edge.
- FSM states: IDLE, LOAD_W, WAIT_W, STREAM, DRAIN, FIN.
- IDLE, on cfg_valid:
  - latch cfg_* and drive row_mode = cfg_mode;
  - if mode is 2'b11, pulse err next cycle, stay IDLE, issue no reads;
  - else if cfg_len == 0, go to FIN;
  - else go to LOAD_W.
- LOAD_W: w_rd_en = 1 and w_rd_addr = wbase for one cycle, then WAIT_W.
- WAIT_W: w_load = 1 for one cycle (buffer read latency is 1), then STREAM.
- STREAM:
  - issue p_rd_en with p_rd_addr = pbase + k for k = 0..len-1, one read per cycle;
  - issue only when inflight + fifo_count < OUT_DEPTH; otherwise hold, with no read that cycle;
  - the address wraps modulo 2^ADDR_W;
  - after the read with k = len-1, go to DRAIN.
- Pipeline, from p_rd_en at cycle t:
  - pixel data reaches the row at t+1;
  - product is registered in the PE and valid at t+2;
  - the registered reduction writes the FIFO at t+3.
  - A 3-deep valid/last shift register carries the tags.
- Reduction: out_psum = sum over lanes i with mask[i] = 1 of sign-extended product[i]; no saturation.
- FIFO:
  - show-ahead; out_valid is visible in the same cycle the entry is written, so first out_valid = t+3 when empty;
  - a write and a read in the same cycle are both allowed, and the count is unchanged;
  - the credit rule guarantees the FIFO never overflows.
- DRAIN: wait until in-flight tags are empty and the out_last entry has been popped, then go to FIN.
- FIN: done = 1 for one cycle, then IDLE; cfg_ready returns high in IDLE.
- cfg_valid outside IDLE is ignored; no queueing.
- Reset asserted mid-job aborts immediately: FIFO is flushed, no done pulse, outputs return to reset values.
- out_ready is ignored while out_valid is low.

Decomposition:
- Package dla_sched_pkg holds:
  - state enum sched_state_e;
  - MODE_* constants, with MODE_ILLEGAL = 2'b11;
  - PIPE_LAT = 3;
  - typedef psum_t = logic signed [ACC_W-1:0].
- One sub-module: sched_out_fifo, a parameterised synchronous show-ahead FIFO with count output.

Test Plan:
- Basic: mode 0, mask 16'hFFFF, len 4, weights all 1, pixels all 1.
  - Expect: w_load once; p_rd_addr = pbase..pbase+3 on consecutive cycles.
  - Expect: four psums of 16; first out_valid 3 cycles after the first p_rd_en; out_last on the 4th; done one cycle after the 4th pop.
- Signed extreme: all weights -128, pixels 255 (products -32640), mask FFFF, len 1 -> out_psum = -522240.
- Backpressure: len 10 with out_ready held 0.
  - Expect: at most 4 p_rd_en issued before any pop.
  - Then toggle out_ready 1/0 -> all 10 psums delivered in order, none lost or duplicated.
- Illegal and empty jobs:
  - cfg_mode 2'b11 -> err pulse, zero reads, cfg_ready stays 1.
  - cfg_len 0 -> done pulse with no reads and no out_valid.
- Reset mid-STREAM (3 of 8 issued) -> all outputs at reset values; a new job then runs cleanly from pbase.
- Mask 16'h7000, mode 1 -> psum sums only lanes 12-14; row_mode = 1 held until done.
